// File: rtl/alu_op_issuer.sv
// alu_op_issuer: initiator side of the ALU control interface.
// Accepts one MIPS R-type instruction with its register operands per handshake,
// decodes funct into a one-hot ALU strobe, holds operands and strobe for a settle
// window, then captures ALU_Output and offers it downstream with valid/ready.
// Optional feature macro: ALU_ISSUE_VARSHIFT_EN enables the variable shifts
// (funct 04/06/07 -> SLL/SRL/SRA, shift amount taken from RegA[4:0]).
module alu_op_issuer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int MULDIV_SETTLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        Instr,
  input  logic [31:0]        RegA,
  input  logic [31:0]        RegB,
  input  logic               InValid,
  output logic               InReady,
  output logic [31:0]        ALU_A,
  output logic [31:0]        ALU_B,
  output logic [31:0]        ALU_C,
  output logic               ADD,
  output logic               SUB,
  output logic               ADDu,
  output logic               SUBu,
  output logic               MUL,
  output logic               DIV,
  output logic               AND,
  output logic               OR,
  output logic               XOR,
  output logic               NOR,
  output logic               SRL,
  output logic               SLL,
  output logic               SRA,
  output logic               SLA,
  output logic               ALU_Enable,
  input  logic [31:0]        ALU_Output,
  output logic signed [31:0] Result,
  output logic               ResultValid,
  input  logic               ResultReady,
  output logic               IllegalOp
);

  // Strobe bit positions inside the registered one-hot op vector.
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_ADDU = 2;
  localparam int OP_SUBU = 3;
  localparam int OP_MUL  = 4;
  localparam int OP_DIV  = 5;
  localparam int OP_AND  = 6;
  localparam int OP_OR   = 7;
  localparam int OP_XOR  = 8;
  localparam int OP_NOR  = 9;
  localparam int OP_SRL  = 10;
  localparam int OP_SLL  = 11;
  localparam int OP_SRA  = 12;
  localparam int OP_SLA  = 13;

  // A zero settle time would capture before the ALU ever saw the strobe.
  localparam int N_ALU = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int N_MD  = (MULDIV_SETTLE < 1) ? 1 : MULDIV_SETTLE;
  localparam logic [15:0] LOAD_ALU = 16'(N_ALU - 1);
  localparam logic [15:0] LOAD_MD  = 16'(N_MD - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  typedef struct packed {
    logic        legal;
    logic        muldiv;
    logic        shift;
    logic        varshift;
    logic [13:0] op;
  } dec_t;

  state_t      state;
  logic [13:0] op_q;
  logic [15:0] cnt;
  dec_t        dec;
  logic        unused_instr;

  // Maps an R-type instruction to its one-hot strobe and operand routing.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    if (instr[31:26] != 6'd0) begin
      d.legal = 1'b0;
    end else begin
      case (instr[5:0])
        6'h20: d.op[OP_ADD]  = 1'b1;
        6'h21: d.op[OP_ADDU] = 1'b1;
        6'h22: d.op[OP_SUB]  = 1'b1;
        6'h23: d.op[OP_SUBU] = 1'b1;
        6'h24: d.op[OP_AND]  = 1'b1;
        6'h25: d.op[OP_OR]   = 1'b1;
        6'h26: d.op[OP_XOR]  = 1'b1;
        6'h27: d.op[OP_NOR]  = 1'b1;
        6'h00: begin d.op[OP_SLL] = 1'b1; d.shift = 1'b1; end
        6'h02: begin d.op[OP_SRL] = 1'b1; d.shift = 1'b1; end
        6'h03: begin d.op[OP_SRA] = 1'b1; d.shift = 1'b1; end
        6'h01: begin d.op[OP_SLA] = 1'b1; d.shift = 1'b1; end
        6'h18: begin d.op[OP_MUL] = 1'b1; d.muldiv = 1'b1; end
        6'h1A: begin d.op[OP_DIV] = 1'b1; d.muldiv = 1'b1; end
`ifdef ALU_ISSUE_VARSHIFT_EN
        6'h04: begin d.op[OP_SLL] = 1'b1; d.varshift = 1'b1; end
        6'h06: begin d.op[OP_SRL] = 1'b1; d.varshift = 1'b1; end
        6'h07: begin d.op[OP_SRA] = 1'b1; d.varshift = 1'b1; end
`endif
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

  assign dec = decode(Instr);

  // rs/rt/rd register-number fields carry no meaning here; operands arrive on RegA/RegB.
  assign unused_instr = ^Instr[25:11];

  assign ADD  = op_q[OP_ADD];
  assign SUB  = op_q[OP_SUB];
  assign ADDu = op_q[OP_ADDU];
  assign SUBu = op_q[OP_SUBU];
  assign MUL  = op_q[OP_MUL];
  assign DIV  = op_q[OP_DIV];
  assign AND  = op_q[OP_AND];
  assign OR   = op_q[OP_OR];
  assign XOR  = op_q[OP_XOR];
  assign NOR  = op_q[OP_NOR];
  assign SRL  = op_q[OP_SRL];
  assign SLL  = op_q[OP_SLL];
  assign SRA  = op_q[OP_SRA];
  assign SLA  = op_q[OP_SLA];

  // Issue FSM: accept in IDLE, hold strobe for the settle window in DRIVE, present result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      InReady     <= 1'b1;
      op_q        <= '0;
      ALU_Enable  <= 1'b0;
      ALU_A       <= '0;
      ALU_B       <= '0;
      ALU_C       <= '0;
      cnt         <= '0;
      Result      <= '0;
      ResultValid <= 1'b0;
      IllegalOp   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            InReady <= 1'b0;
            if (dec.legal) begin
              state      <= DRIVE;
              op_q       <= dec.op;
              ALU_Enable <= 1'b1;
              ALU_A      <= dec.varshift ? 32'd0 : RegA;
              ALU_B      <= RegB;
              if (dec.varshift)   ALU_C <= {27'b0, RegA[4:0]};
              else if (dec.shift) ALU_C <= {27'b0, Instr[10:6]};
              else                ALU_C <= 32'd0;
              cnt        <= dec.muldiv ? LOAD_MD : LOAD_ALU;
            end else begin
              // Undecodable: skip the ALU entirely and report straight away.
              state       <= DONE;
              Result      <= '0;
              IllegalOp   <= 1'b1;
              ResultValid <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (cnt == 16'd0) begin
            state       <= DONE;
            op_q        <= '0;
            ALU_Enable  <= 1'b0;
            Result      <= ALU_Output;
            ResultValid <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DONE: begin
          if (ResultReady) begin
            state       <= IDLE;
            InReady     <= 1'b1;
            ResultValid <= 1'b0;
            IllegalOp   <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          InReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Testbench for alu_op_issuer with a behavioural combinational ALU on the ALU side.
// Expected results are queued when an instruction is issued and popped when the
// issuer presents its result.
module tb_alu_op_issuer;

  localparam int N_ALU = 1;
  localparam int N_MD  = 4;

  // Bit positions of the strobe vector assembled below.
  localparam int S_ADD = 13, S_SUB = 12, S_ADDU = 11, S_SUBU = 10, S_MUL = 9, S_DIV = 8;
  localparam int S_AND = 7, S_OR = 6, S_XOR = 5, S_NOR = 4, S_SRL = 3, S_SLL = 2, S_SRA = 1, S_SLA = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] Instr = '0, RegA = '0, RegB = '0;
  logic InValid = 1'b0, ResultReady = 1'b0;
  logic InReady, ALU_Enable, ResultValid, IllegalOp;
  logic [31:0] ALU_A, ALU_B, ALU_C, ALU_Output;
  logic signed [31:0] Result;
  logic ADD, SUB, ADDu, SUBu, MUL, DIV, AND, OR, XOR, NOR, SRL, SLL, SRA, SLA;
  logic [13:0] stb;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ill;
    logic [13:0] stb;
    logic [31:0] a;
    logic [31:0] c;
    int          n;
  } exp_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t        e;
  } vec_t;

  typedef struct packed {
    int          en;
    int          lat;
    logic [13:0] seen;
    logic        multi;
    logic        to;
    logic [31:0] a;
    logic [31:0] c;
  } obs_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  alu_op_issuer #(.SETTLE_CYCLES(N_ALU), .MULDIV_SETTLE(N_MD)) dut (
    .clk(clk), .rst(rst), .Instr(Instr), .RegA(RegA), .RegB(RegB),
    .InValid(InValid), .InReady(InReady),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_C(ALU_C),
    .ADD(ADD), .SUB(SUB), .ADDu(ADDu), .SUBu(SUBu), .MUL(MUL), .DIV(DIV),
    .AND(AND), .OR(OR), .XOR(XOR), .NOR(NOR), .SRL(SRL), .SLL(SLL), .SRA(SRA), .SLA(SLA),
    .ALU_Enable(ALU_Enable), .ALU_Output(ALU_Output),
    .Result(Result), .ResultValid(ResultValid), .ResultReady(ResultReady),
    .IllegalOp(IllegalOp)
  );

  assign stb = {ADD, SUB, ADDu, SUBu, MUL, DIV, AND, OR, XOR, NOR, SRL, SLL, SRA, SLA};

  // Behavioural ALU; division by zero yields a recognisable marker.
  function automatic logic [31:0] alu_fn(input logic [13:0] s, input logic [31:0] a, b, c);
    logic signed [31:0] sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    r  = 32'h0;
    if (s[S_ADD] || s[S_ADDU]) r = a + b;
    else if (s[S_SUB] || s[S_SUBU]) r = a - b;
    else if (s[S_MUL]) r = sa * sb;
    else if (s[S_DIV]) begin
      if (b == 32'd0) r = 32'hDEADBEEF;
      else r = sa / sb;
    end
    else if (s[S_AND]) r = a & b;
    else if (s[S_OR])  r = a | b;
    else if (s[S_XOR]) r = a ^ b;
    else if (s[S_NOR]) r = ~(a | b);
    else if (s[S_SRL]) r = b >> c[4:0];
    else if (s[S_SLL] || s[S_SLA]) r = b << c[4:0];
    else if (s[S_SRA]) r = sb >>> c[4:0];
    return r;
  endfunction

  always_comb begin
    ALU_Output = 32'h0;
    if (ALU_Enable) ALU_Output = alu_fn(stb, ALU_A, ALU_B, ALU_C);
  end

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] sh);
    return {6'd0, 15'd0, sh, f};
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, ra, rb, res, a, c, input int sbit, input int n);
    vec_t v;
    v.ins   = ins;
    v.ra    = ra;
    v.rb    = rb;
    v.e.res = res;
    v.e.ill = 1'b0;
    v.e.stb = 14'd1 << sbit;
    v.e.a   = a;
    v.e.c   = c;
    v.e.n   = n;
    return v;
  endfunction

  // Drives one instruction and follows it until ResultValid rises (bounded).
  task automatic run_op(input logic [31:0] ins, ra, rb, output obs_t o);
    o = '0;
    @(negedge clk);
    Instr = ins; RegA = ra; RegB = rb; InValid = 1'b1;
    @(posedge clk);
    #1 InValid = 1'b0;
    o.lat = 1;
    while (!ResultValid) begin
      if (ALU_Enable) begin
        o.en++;
        o.a = ALU_A;
        o.c = ALU_C;
      end
      if (ALU_Enable ? ($countones(stb) != 1) : (stb != 14'd0)) o.multi = 1'b1;
      o.seen |= stb;
      if (o.lat > 50) begin
        o.to = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      o.lat++;
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    ResultReady = 1'b1;
    @(posedge clk);
    #1 ResultReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stb, ALU_Enable, ResultValid, IllegalOp} !== 17'd0) begin
      errors++;
      $display("FAIL reset_ctrl: strobes/en/valid/illegal got %h required 0", {stb, ALU_Enable, ResultValid, IllegalOp});
    end
    checks++;
    if ({ALU_A, ALU_B, ALU_C, Result} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: A=%h B=%h C=%h Result=%h required all 0", ALU_A, ALU_B, ALU_C, Result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_inready: got %b required 1", InReady);
    end
    // A stray ResultReady with nothing valid must not disturb the idle issuer.
    @(negedge clk);
    ResultReady = 1'b1;
    repeat (2) @(posedge clk);
    #1 ResultReady = 1'b0;
    checks++;
    if ({InReady, ResultValid, ALU_Enable} !== 3'b100) begin
      errors++;
      $display("FAIL reset_stray_ready: InReady/ResultValid/ALU_Enable got %b required 100", {InReady, ResultValid, ALU_Enable});
    end
  endtask

  task automatic test_ops();
    vec_t v[$];
    obs_t o;
    exp_t e;
    v.push_back(mk({6'd0, 5'd3, 5'd5, 5'd7, 5'd0, 6'h20}, -3, 5, 2, -3, 0, S_ADD, N_ALU));
    v.push_back(mk(rtype(6'h03, 5'd1), 32'd0, -3, 32'hFFFFFFFE, 0, 1, S_SRA, N_ALU));
    v.push_back(mk(rtype(6'h02, 5'd1), 32'd0, -3, 32'd2147483646, 0, 1, S_SRL, N_ALU));
    v.push_back(mk(rtype(6'h18, 5'd0), -8, 4, -32, -8, 0, S_MUL, N_MD));
    v.push_back(mk(rtype(6'h1A, 5'd0), 8, 4, 2, 8, 0, S_DIV, N_MD));
    v.push_back(mk(rtype(6'h1A, 5'd0), 7, 0, 32'hDEADBEEF, 7, 0, S_DIV, N_MD));
    v.push_back(mk(rtype(6'h22, 5'd0), 10, 3, 7, 10, 0, S_SUB, N_ALU));
    v.push_back(mk(rtype(6'h21, 5'd0), 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, S_ADDU, N_ALU));
    v.push_back(mk(rtype(6'h23, 5'd0), 0, 1, 32'hFFFFFFFF, 0, 0, S_SUBU, N_ALU));
    v.push_back(mk(rtype(6'h24, 5'd0), 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'hF0F0F0F0, 0, S_AND, N_ALU));
    v.push_back(mk(rtype(6'h25, 5'd0), 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'hF0F0F0F0, 0, S_OR, N_ALU));
    v.push_back(mk(rtype(6'h26, 5'd0), 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 0, S_XOR, N_ALU));
    v.push_back(mk(rtype(6'h27, 5'd0), 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'hF0F0F0F0, 0, S_NOR, N_ALU));
    v.push_back(mk(rtype(6'h00, 5'd4), 32'd9, 1, 16, 9, 4, S_SLL, N_ALU));
    v.push_back(mk(rtype(6'h01, 5'd31), 32'd9, 1, 32'h80000000, 9, 31, S_SLA, N_ALU));
    foreach (v[i]) begin
      sbq.push_back(v[i].e);
      run_op(v[i].ins, v[i].ra, v[i].rb, o);
      e = sbq.pop_front();
      checks++;
      if (o.to) begin errors++; $display("FAIL op%0d_timeout: no ResultValid after %0d edges", i, o.lat); end
      checks++;
      if (Result !== e.res) begin errors++; $display("FAIL op%0d_result: instr %h got %h required %h", i, v[i].ins, Result, e.res); end
      checks++;
      if (IllegalOp !== e.ill) begin errors++; $display("FAIL op%0d_illegal: got %b required %b", i, IllegalOp, e.ill); end
      checks++;
      if (o.seen !== e.stb) begin errors++; $display("FAIL op%0d_strobe: got %b required %b", i, o.seen, e.stb); end
      checks++;
      if (o.en !== e.n) begin errors++; $display("FAIL op%0d_enable_cycles: got %0d required %0d", i, o.en, e.n); end
      checks++;
      if (o.lat !== e.n + 1) begin errors++; $display("FAIL op%0d_latency: valid at edge %0d required %0d", i, o.lat, e.n + 1); end
      checks++;
      if (o.multi !== 1'b0) begin errors++; $display("FAIL op%0d_onehot: strobe vector not one-hot while enabled (got flag %b)", i, o.multi); end
      checks++;
      if ({o.a, o.c} !== {e.a, e.c}) begin errors++; $display("FAIL op%0d_operands: A=%h C=%h required A=%h C=%h", i, o.a, o.c, e.a, e.c); end
      checks++;
      if ({stb, ALU_Enable} !== 15'd0) begin errors++; $display("FAIL op%0d_clear: strobes/en got %h required 0", i, {stb, ALU_Enable}); end
      finish_op();
      checks++;
      if ({ResultValid, IllegalOp, InReady} !== 3'b001) begin
        errors++;
        $display("FAIL op%0d_handshake: valid/illegal/inready got %b required 001", i, {ResultValid, IllegalOp, InReady});
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins[2];
    obs_t o;
    exp_t e;
    ins[0] = {6'h23, 20'd0, 6'h20};
    ins[1] = rtype(6'h3F, 5'd0);
    for (int i = 0; i < 2; i++) begin
      e = '0;
      e.ill = 1'b1;
      sbq.push_back(e);
      run_op(ins[i], 32'd11, 32'd22, o);
      e = sbq.pop_front();
      checks++;
      if ({o.en, o.seen} !== {32'd0, 14'd0}) begin errors++; $display("FAIL ill%0d_no_strobe: enable cycles %0d strobes %b required 0", i, o.en, o.seen); end
      checks++;
      if ({Result, IllegalOp, ResultValid} !== {e.res, e.ill, 1'b1}) begin
        errors++;
        $display("FAIL ill%0d_report: Result=%h Illegal=%b Valid=%b required %h 1 1", i, Result, IllegalOp, ResultValid, e.res);
      end
      checks++;
      if (o.lat !== 1) begin errors++; $display("FAIL ill%0d_latency: valid at edge %0d required 1", i, o.lat); end
      // Hold downstream off while a new request waits upstream.
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        Instr = rtype(6'h20, 5'd0); RegA = 1; RegB = 1; InValid = 1'b1;
        checks++;
        if ({ResultValid, IllegalOp, Result, InReady, ALU_Enable} !== {1'b1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL ill%0d_hold%0d: valid=%b illegal=%b result=%h inready=%b en=%b required 1 1 0 0 0",
                   i, k, ResultValid, IllegalOp, Result, InReady, ALU_Enable);
        end
      end
      @(negedge clk);
      InValid = 1'b0;
      finish_op();
      checks++;
      if ({ResultValid, IllegalOp, InReady} !== 3'b001) begin
        errors++;
        $display("FAIL ill%0d_handshake: valid/illegal/inready got %b required 001", i, {ResultValid, IllegalOp, InReady});
      end
    end
  endtask

  task automatic test_varshift();
    obs_t o;
    exp_t e;
`ifdef ALU_ISSUE_VARSHIFT_EN
    e.res = -6; e.ill = 1'b0; e.stb = 14'd1 << S_SLL; e.a = 0; e.c = 1; e.n = N_ALU;
`else
    e = '0;
    e.ill = 1'b1;
`endif
    sbq.push_back(e);
    run_op(rtype(6'h04, 5'd0), 32'd1, -3, o);
    e = sbq.pop_front();
    checks++;
    if ({Result, IllegalOp} !== {e.res, e.ill}) begin
      errors++;
      $display("FAIL varshift_result: Result=%h Illegal=%b required %h %b", Result, IllegalOp, e.res, e.ill);
    end
    checks++;
    if ({o.seen, o.a, o.c} !== {e.stb, e.a, e.c}) begin
      errors++;
      $display("FAIL varshift_drive: strobes=%b A=%h C=%h required %b %h %h", o.seen, o.a, o.c, e.stb, e.a, e.c);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[3], ra[3], rb[3], rs[3];
    int acc[3];
    int k, npop;
    logic just_acc;
    exp_t e;
    ins[0] = rtype(6'h20, 5'd0); ra[0] = 1; rb[0] = 2; rs[0] = 3;
    ins[1] = rtype(6'h22, 5'd0); ra[1] = 9; rb[1] = 4; rs[1] = 5;
    ins[2] = rtype(6'h26, 5'd0); ra[2] = 3; rb[2] = 5; rs[2] = 6;
    acc = '{0, 0, 0};
    k = 0;
    npop = 0;
    just_acc = 1'b0;
    @(negedge clk);
    ResultReady = 1'b1;
    Instr = ins[0]; RegA = ra[0]; RegB = rb[0]; InValid = 1'b1;
    for (int cyc = 0; cyc < 60 && npop < 3; cyc++) begin
      if (just_acc) begin
        just_acc = 1'b0;
        if (k < 3) begin Instr = ins[k]; RegA = ra[k]; RegB = rb[k]; end
        else InValid = 1'b0;
      end
      if (ResultValid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected: result %h with nothing outstanding", Result);
        end else begin
          e = sbq.pop_front();
          if ({Result, IllegalOp} !== {e.res, e.ill}) begin
            errors++;
            $display("FAIL b2b_result%0d: got %h/%b required %h/%b", npop, Result, IllegalOp, e.res, e.ill);
          end
        end
        npop++;
      end
      if (InValid && InReady && k < 3) begin
        acc[k] = cyc;
        e = '0;
        e.res = rs[k];
        sbq.push_back(e);
        k++;
        just_acc = 1'b1;
      end
      @(negedge clk);
    end
    ResultReady = 1'b0;
    InValid = 1'b0;
    checks++;
    if (npop !== 3) begin errors++; $display("FAIL b2b_count: got %0d results required 3", npop); end
    checks++;
    if ({acc[1] - acc[0], acc[2] - acc[1]} !== {N_ALU + 2, N_ALU + 2}) begin
      errors++;
      $display("FAIL b2b_spacing: accept gaps %0d,%0d required %0d", acc[1] - acc[0], acc[2] - acc[1], N_ALU + 2);
    end
  endtask

  task automatic test_reset_mid_drive();
    int seen;
    obs_t o;
    exp_t e;
    @(negedge clk);
    Instr = rtype(6'h18, 5'd0); RegA = -8; RegB = 4; InValid = 1'b1;
    @(posedge clk);
    #1 InValid = 1'b0;
    checks++;
    if ({ALU_Enable, MUL} !== 2'b11) begin errors++; $display("FAIL rstmid_drive: en/MUL got %b required 11", {ALU_Enable, MUL}); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({stb, ALU_Enable, ResultValid, IllegalOp, InReady} !== 18'd1) begin
      errors++;
      $display("FAIL rstmid_state: strobes/en/valid/illegal/inready got %h required 1", {stb, ALU_Enable, ResultValid, IllegalOp, InReady});
    end
    @(negedge clk);
    rst = 1'b0;
    ResultReady = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ResultValid || ALU_Enable) seen++;
    end
    ResultReady = 1'b0;
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rstmid_ghost: %0d cycles with valid/enable after reset required 0", seen); end
    e = '0;
    e.res = 9;
    e.n = N_ALU;
    sbq.push_back(e);
    run_op(rtype(6'h20, 5'd0), 4, 5, o);
    e = sbq.pop_front();
    checks++;
    if ({Result, o.lat} !== {e.res, e.n + 1}) begin
      errors++;
      $display("FAIL rstmid_recover: Result=%h latency=%0d required %h %0d", Result, o.lat, e.res, e.n + 1);
    end
    finish_op();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ops();
    test_illegal();
    test_varshift();
    test_back_to_back();
    test_reset_mid_drive();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected results never produced, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
